sram_arbiter: RTL and testbench



---
 rtl/sram_arb_pkg.sv | 31 +++
 rtl/sram_arb_pick.sv | 52 +++++
 rtl/sram_arbiter.sv | 154 +++++++++++++++
 tb/tb_sram_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM arbiter.
// - state_t: access sequencer states.
// - ADDR_W_DEF / DATA_W_DEF: default SRAM address and data widths.
// - STREAK_W: width of the video-streak counter. It must hold MAX_VID_STREAK, which is at most 255.
// - OWN_VID / OWN_HOST: encoding of which requester owns the in-flight access.
package sram_arb_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam int STREAK_W   = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_SETUP  = 3'd1,
    RD_SAMPLE = 3'd2,
    WR_SETUP  = 3'd3,
    WR_PULSE  = 3'd4,
    WR_HOLD   = 3'd5
  } state_t;

  localparam logic OWN_VID  = 1'b0;
  localparam logic OWN_HOST = 1'b1;

  // A new access may be granted only in these states. The grant is issued in
  // the last cycle of the previous access, so back-to-back accesses need no
  // idle cycle between them.
  function automatic logic is_arb_point(input state_t s);
    return (s == IDLE) || (s == RD_SAMPLE) || (s == WR_HOLD);
  endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// Winner select and video-streak counter.
// Ports:
//   clk50mhz, reset_n : clock and asynchronous active-low reset
//   arb_en            : the sequencer is at an arbitration point this cycle
//   vid_req, host_req : pending requests
//   grant_vid         : combinational grant for the video requester
//   grant_host        : combinational grant for the host requester
//   streak            : video grants made while the host was waiting (registered)
module sram_arb_pick
  import sram_arb_pkg::*;
#(
  parameter int MAX_VID_STREAK = 8
) (
  input  logic                clk50mhz,
  input  logic                reset_n,
  input  logic                arb_en,
  input  logic                vid_req,
  input  logic                host_req,
  output logic                grant_vid,
  output logic                grant_host,
  output logic [STREAK_W-1:0] streak
);

  localparam logic [STREAK_W-1:0] MAX_S = STREAK_W'(MAX_VID_STREAK);

  // Video normally wins. Once the streak reaches MAX_S, a waiting host is
  // served first, so the host always gets a grant within bounded time.
  always_comb begin
    grant_vid  = 1'b0;
    grant_host = 1'b0;
    if (arb_en) begin
      if (host_req && (!vid_req || streak == MAX_S)) begin
        grant_host = 1'b1;
      end else if (vid_req) begin
        grant_vid = 1'b1;
      end
    end
  end

  // The streak counts only while the host is actually waiting. It clears
  // when the host is granted and whenever host_req is low.
  always_ff @(posedge clk50mhz or negedge reset_n) begin
    if (!reset_n) begin
      streak <= '0;
    end else if (!host_req || grant_host) begin
      streak <= '0;
    end else if (grant_vid && streak != MAX_S) begin
      streak <= streak + 1'b1;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one asynchronous 16-bit SRAM between the video fetch path and the
// host/loader port. Each access runs as a fixed setup/strobe/hold sequence.
// Ports:
//   clk50mhz, reset_n   : clock and asynchronous active-low reset
//   vid_req/vid_addr    : video read request
//   vid_ack             : one-cycle pulse, video request accepted
//   vid_rdata/vid_rvalid: video read result
//   host_req/host_we/host_addr/host_wdata : host request
//   host_ack            : one-cycle pulse, host request accepted
//   host_rdata/host_rvalid : host read result
//   sram_addr, sram_we_n, sram_oe_n : SRAM control
//   sram_dq_out, sram_dq_oe, sram_dq_in : split data pad (the tri-state buffer sits one level up)
//   dbg_state, dbg_streak : sequencer state and streak counter, for observation
//
// Handshake: a requester holds req (and its address/data) high until it sees
// ack. It must drop req in the cycle after ack. If req is still high two
// cycles after ack, it is a new request. rvalid is a one-cycle pulse with
// rdata valid in the same cycle. Reads complete in grant order, and only one
// access is in flight at a time.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int MAX_VID_STREAK = 8
) (
  input  logic                clk50mhz,
  input  logic                reset_n,
  input  logic                vid_req,
  input  logic [ADDR_W-1:0]   vid_addr,
  output logic                vid_ack,
  output logic [DATA_W-1:0]   vid_rdata,
  output logic                vid_rvalid,
  input  logic                host_req,
  input  logic                host_we,
  input  logic [ADDR_W-1:0]   host_addr,
  input  logic [DATA_W-1:0]   host_wdata,
  output logic                host_ack,
  output logic [DATA_W-1:0]   host_rdata,
  output logic                host_rvalid,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic                sram_we_n,
  output logic                sram_oe_n,
  output logic [DATA_W-1:0]   sram_dq_out,
  output logic                sram_dq_oe,
  input  logic [DATA_W-1:0]   sram_dq_in,
  output logic [2:0]          dbg_state,
  output logic [STREAK_W-1:0] dbg_streak
);

  state_t state;
  logic   owner;
  logic   arb_en;
  logic   grant_vid;
  logic   grant_host;
  logic   grant_wr;

  assign arb_en    = is_arb_point(state);
  assign grant_wr  = grant_host & host_we;
  assign dbg_state = state;

  sram_arb_pick #(
    .MAX_VID_STREAK(MAX_VID_STREAK)
  ) u_pick (
    .clk50mhz  (clk50mhz),
    .reset_n   (reset_n),
    .arb_en    (arb_en),
    .vid_req   (vid_req),
    .host_req  (host_req),
    .grant_vid (grant_vid),
    .grant_host(grant_host),
    .streak    (dbg_streak)
  );

  always_ff @(posedge clk50mhz or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      owner       <= OWN_VID;
      sram_addr   <= '0;
      sram_we_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      vid_ack     <= 1'b0;
      vid_rdata   <= '0;
      vid_rvalid  <= 1'b0;
      host_ack    <= 1'b0;
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
    end else begin
      vid_ack     <= 1'b0;
      host_ack    <= 1'b0;
      vid_rvalid  <= 1'b0;
      host_rvalid <= 1'b0;

      case (state)
        RD_SETUP: begin
          state <= RD_SAMPLE;
        end
        RD_SAMPLE: begin
          // Capture the read data at the end of the second output-enable cycle.
          if (owner == OWN_HOST) begin
            host_rdata  <= sram_dq_in;
            host_rvalid <= 1'b1;
          end else begin
            vid_rdata   <= sram_dq_in;
            vid_rvalid  <= 1'b1;
          end
        end
        WR_SETUP: begin
          state      <= WR_PULSE;
          sram_we_n  <= 1'b0;
          sram_dq_oe <= 1'b1;
        end
        WR_PULSE: begin
          state     <= WR_HOLD;
          sram_we_n <= 1'b1;
        end
        default: begin
        end
      endcase

      // Arbitration overrides the state and pad controls above when it runs.
      // Address and data change only here, and we_n is high at every
      // arbitration point.
      if (arb_en) begin
        if (grant_vid || grant_host) begin
          owner     <= grant_host ? OWN_HOST : OWN_VID;
          sram_addr <= grant_host ? host_addr : vid_addr;
          vid_ack   <= grant_vid;
          host_ack  <= grant_host;
          if (grant_wr) begin
            state       <= WR_SETUP;
            sram_dq_out <= host_wdata;
            sram_oe_n   <= 1'b1;
            // Write after write: the pad is already driven and output enable is
            // already off, so drive stays on. After a read or from idle, drive
            // stays off for one cycle to turn the bus around.
            sram_dq_oe  <= (state == WR_HOLD);
          end else begin
            state      <= RD_SETUP;
            sram_oe_n  <= 1'b0;
            sram_dq_oe <= 1'b0;
          end
        end else begin
          state      <= IDLE;
          sram_oe_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int MAXS = 4;

  logic          clk50mhz = 1'b0;
  logic          reset_n  = 1'b1;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_ack;
  logic [DW-1:0] vid_rdata;
  logic          vid_rvalid;
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_ack;
  logic [DW-1:0] host_rdata;
  logic          host_rvalid;
  logic [AW-1:0] sram_addr;
  logic          sram_we_n;
  logic          sram_oe_n;
  logic [DW-1:0] sram_dq_out;
  logic          sram_dq_oe;
  logic [DW-1:0] sram_dq_in = '0;
  logic [2:0]    dbg_state;
  logic [7:0]    dbg_streak;

  int checks = 0;
  int errors = 0;
  int contention_viol = 0;
  int addr_viol = 0;

  logic [DW-1:0] host_exp_q[$];
  logic [DW-1:0] vid_exp_q[$];

  typedef struct {
    logic          is_host;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];
  vec_t bb[5];
  int   gaps[4] = '{3, 2, 3, 2};

  // ---------------- clock ----------------
  always #5 clk50mhz = ~clk50mhz;

  sram_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_VID_STREAK(MAXS)
  ) dut (
    .clk50mhz   (clk50mhz),
    .reset_n    (reset_n),
    .vid_req    (vid_req),
    .vid_addr   (vid_addr),
    .vid_ack    (vid_ack),
    .vid_rdata  (vid_rdata),
    .vid_rvalid (vid_rvalid),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_rdata (host_rdata),
    .host_rvalid(host_rvalid),
    .sram_addr  (sram_addr),
    .sram_we_n  (sram_we_n),
    .sram_oe_n  (sram_oe_n),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_in (sram_dq_in),
    .dbg_state  (dbg_state),
    .dbg_streak (dbg_streak)
  );

  // ---------------- SRAM model + monitors ----------------
  // A location that has never been written reads back as addr ^ 0x00E5,
  // so address 0x0040 returns 0x00A5.
  logic [DW-1:0] wr_mem [logic [AW-1:0]];
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] sb_exp;

  function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
    if (wr_mem.exists(a)) return wr_mem[a];
    return a ^ 16'h00E5;
  endfunction

  always @(negedge clk50mhz) begin
    assert (!(sram_dq_oe && !sram_oe_n)) else contention_viol++;
    if (reset_n && !sram_we_n && sram_addr != prev_addr) addr_viol++;
    prev_addr = sram_addr;
    if (!sram_we_n && sram_dq_oe) wr_mem[sram_addr] = sram_dq_out;
    sram_dq_in = !sram_oe_n ? mem_read(sram_addr) : '0;

    if (host_rvalid) begin
      checks++;
      if (host_exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_host_rdata: unexpected rvalid, got %h, none expected", host_rdata);
      end else begin
        sb_exp = host_exp_q.pop_front();
        if (host_rdata !== sb_exp) begin
          errors++;
          $display("FAIL sb_host_rdata: got %h expected %h", host_rdata, sb_exp);
        end
      end
    end
    if (vid_rvalid) begin
      checks++;
      if (vid_exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_vid_rdata: unexpected rvalid, got %h, none expected", vid_rdata);
      end else begin
        sb_exp = vid_exp_q.pop_front();
        if (vid_rdata !== sb_exp) begin
          errors++;
          $display("FAIL sb_vid_rdata: got %h expected %h", vid_rdata, sb_exp);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk50mhz);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one isolated access from IDLE and checks every cycle of its sequence.
  task automatic run_vec(input vec_t v, input int idx);
    if (v.is_host) begin
      host_req = 1'b1; host_we = v.we; host_addr = v.addr; host_wdata = v.wdata;
    end else begin
      vid_req = 1'b1; vid_addr = v.addr;
    end
    step();
    chk($sformatf("v%0d_ack", idx), v.is_host ? host_ack : vid_ack, 1);
    chk($sformatf("v%0d_other_ack", idx), v.is_host ? vid_ack : host_ack, 0);
    chk($sformatf("v%0d_addr", idx), sram_addr, v.addr);
    host_req = 1'b0;
    vid_req  = 1'b0;
    if (v.we) begin
      chk($sformatf("v%0d_setup_we_n", idx), sram_we_n, 1);
      chk($sformatf("v%0d_setup_dq_oe", idx), sram_dq_oe, 0);
      step();
      chk($sformatf("v%0d_pulse_we_n", idx), sram_we_n, 0);
      chk($sformatf("v%0d_pulse_dq_oe", idx), sram_dq_oe, 1);
      chk($sformatf("v%0d_pulse_dq_out", idx), sram_dq_out, v.wdata);
      chk($sformatf("v%0d_pulse_oe_n", idx), sram_oe_n, 1);
      step();
      chk($sformatf("v%0d_hold_we_n", idx), sram_we_n, 1);
      chk($sformatf("v%0d_hold_dq_oe", idx), sram_dq_oe, 1);
      step();
      chk($sformatf("v%0d_end_dq_oe", idx), sram_dq_oe, 0);
      chk($sformatf("v%0d_end_rvalid", idx), host_rvalid | vid_rvalid, 0);
      chk($sformatf("v%0d_end_state", idx), dbg_state, 0);
    end else begin
      chk($sformatf("v%0d_setup_oe_n", idx), sram_oe_n, 0);
      if (v.is_host) host_exp_q.push_back(v.exp_rdata);
      else vid_exp_q.push_back(v.exp_rdata);
      step();
      chk($sformatf("v%0d_early_rvalid", idx), host_rvalid | vid_rvalid, 0);
      chk($sformatf("v%0d_sample_oe_n", idx), sram_oe_n, 0);
      step();
      chk($sformatf("v%0d_rvalid", idx), v.is_host ? host_rvalid : vid_rvalid, 1);
      chk($sformatf("v%0d_rdata", idx), v.is_host ? host_rdata : vid_rdata, v.exp_rdata);
      chk($sformatf("v%0d_end_oe_n", idx), sram_oe_n, 1);
      chk($sformatf("v%0d_end_state", idx), dbg_state, 0);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    int vid_grants;
    logic got_host;
    int bidx;
    int cyc;
    int last_ack;

    vid_req = 0; vid_addr = '0;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;

    vecs[0] = '{1'b1, 1'b1, 16'h1234, 16'hBEEF, 16'h0000};
    vecs[1] = '{1'b1, 1'b0, 16'h1234, 16'h0000, 16'hBEEF};
    vecs[2] = '{1'b0, 1'b0, 16'h0040, 16'h0000, 16'h00A5};
    vecs[3] = '{1'b1, 1'b1, 16'h0040, 16'h5A5A, 16'h0000};
    vecs[4] = '{1'b0, 1'b0, 16'h0040, 16'h0000, 16'h5A5A};
    vecs[5] = '{1'b1, 1'b0, 16'h00FF, 16'h0000, 16'h001A};
    vecs[6] = '{1'b1, 1'b1, 16'hFFFF, 16'h0001, 16'h0000};
    vecs[7] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0001};

    bb[0] = '{1'b1, 1'b1, 16'h2000, 16'h1111, 16'h0000};
    bb[1] = '{1'b1, 1'b0, 16'h2000, 16'h0000, 16'h1111};
    bb[2] = '{1'b1, 1'b1, 16'h2001, 16'h2222, 16'h0000};
    bb[3] = '{1'b1, 1'b0, 16'h2001, 16'h0000, 16'h2222};
    bb[4] = '{1'b1, 1'b0, 16'h2000, 16'h0000, 16'h1111};

    // Reset values.
    #1 reset_n = 1'b0;
    #1;
    chk("rst_we_n", sram_we_n, 1);
    chk("rst_oe_n", sram_oe_n, 1);
    chk("rst_dq_oe", sram_dq_oe, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_dq_out", sram_dq_out, 0);
    chk("rst_vid_rdata", vid_rdata, 0);
    chk("rst_host_rdata", host_rdata, 0);
    chk("rst_acks", {vid_ack, host_ack}, 0);
    chk("rst_rvalids", {vid_rvalid, host_rvalid}, 0);
    chk("rst_state", dbg_state, 0);
    chk("rst_streak", dbg_streak, 0);
    step(); step();
    reset_n = 1'b1;
    step();

    // Table-driven isolated accesses.
    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Simultaneous requests: video first, host at the next arbitration point.
    vid_req = 1; vid_addr = 16'h0041;
    host_req = 1; host_we = 0; host_addr = 16'h1234;
    step();
    chk("sim_vid_ack", vid_ack, 1);
    chk("sim_host_ack_first", host_ack, 0);
    chk("sim_streak_1", dbg_streak, 1);
    vid_exp_q.push_back(16'h00A4);
    vid_req = 0;
    step();
    chk("sim_host_ack_wait", host_ack, 0);
    step();
    chk("sim_host_ack", host_ack, 1);
    chk("sim_vid_rvalid", vid_rvalid, 1);
    chk("sim_streak_clr", dbg_streak, 0);
    chk("sim_rd_rd_oe_n", sram_oe_n, 0);
    host_exp_q.push_back(16'hBEEF);
    host_req = 0;
    step(); step();
    chk("sim_host_rvalid", host_rvalid, 1);
    step();

    // Starvation: video held continuously while the host waits.
    vid_req = 1; vid_addr = 16'h0300;
    host_req = 1; host_we = 0; host_addr = 16'h0100;
    vid_grants = 0;
    got_host = 0;
    for (int c = 0; c < 30 && !got_host; c++) begin
      step();
      if (vid_ack) begin
        vid_grants++;
        vid_exp_q.push_back(16'h03E5);
        chk("starve_streak_inc", dbg_streak, vid_grants);
      end
      if (host_ack) begin
        got_host = 1;
        host_exp_q.push_back(16'h01E5);
      end
    end
    chk("starve_host_granted", got_host, 1);
    chk("starve_vid_grants", vid_grants, MAXS);
    chk("starve_streak_clear", dbg_streak, 0);
    host_req = 0; vid_req = 0;
    repeat (6) step();

    // Back-to-back write/read/write/read/read with req held across items.
    bidx = 0; cyc = 0; last_ack = 0;
    host_req = 1; host_we = bb[0].we; host_addr = bb[0].addr; host_wdata = bb[0].wdata;
    for (int c = 0; c < 40 && bidx < 5; c++) begin
      step();
      cyc++;
      if (host_ack) begin
        if (bidx > 0) chk($sformatf("b2b_gap%0d", bidx), cyc - last_ack, gaps[bidx-1]);
        if (!bb[bidx].we) host_exp_q.push_back(bb[bidx].exp_rdata);
        last_ack = cyc;
        bidx++;
        if (bidx < 5) begin
          host_we = bb[bidx].we; host_addr = bb[bidx].addr; host_wdata = bb[bidx].wdata;
        end else begin
          host_req = 0;
        end
      end
    end
    chk("b2b_done", bidx, 5);
    host_req = 0;
    repeat (5) step();

    // Reset in the middle of a write strobe.
    host_req = 1; host_we = 1; host_addr = 16'h3000; host_wdata = 16'hDEAD;
    step();
    host_req = 0;
    step();
    chk("rstw_pre_we_n", sram_we_n, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("rstw_we_n", sram_we_n, 1);
    chk("rstw_dq_oe", sram_dq_oe, 0);
    chk("rstw_oe_n", sram_oe_n, 1);
    chk("rstw_state", dbg_state, 0);
    step();
    reset_n = 1'b1;
    step();

    // Reset in the sample cycle of a read: no rvalid afterwards.
    host_req = 1; host_we = 0; host_addr = 16'h1234;
    step();
    chk("rstr_ack", host_ack, 1);
    host_req = 0;
    step();
    chk("rstr_pre_oe_n", sram_oe_n, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("rstr_oe_n", sram_oe_n, 1);
    chk("rstr_acks_rvalids", {vid_ack, host_ack, vid_rvalid, host_rvalid}, 0);
    chk("rstr_dq_oe", sram_dq_oe, 0);
    step();
    chk("rstr_no_rvalid", host_rvalid, 0);
    reset_n = 1'b1;
    step(); step();
    chk("rstr_no_late_rvalid", host_rvalid, 0);
    chk("rstr_state", dbg_state, 0);

    // Global invariants and scoreboard drain.
    chk("contention_viol", contention_viol, 0);
    chk("addr_change_while_we", addr_viol, 0);
    chk("host_q_empty", host_exp_q.size(), 0);
    chk("vid_q_empty", vid_exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
